// File: rtl/disp_pkg.sv
// Shared register map, reset values and field positions for the display register bank.
package disp_pkg;

    localparam int REG_CW_CS      = 0;
    localparam int REG_X_ORIG     = 1;
    localparam int REG_Y_ORIG     = 2;
    localparam int REG_X_SIZE     = 3;
    localparam int REG_Y_SIZE     = 4;
    localparam int REG_CB_ORIG_LO = 5;
    localparam int REG_CB_ORIG_HI = 6;
    localparam int REG_CHAR_RGL   = 7;
    localparam int REG_GRAPH_RGL  = 8;
    localparam int REG_CW_ROW     = 9;
    localparam int REG_CW_COL     = 10;
    localparam int REG_CB_WR_DATA = 11;
    localparam int REG_STATUS     = 12;
    localparam int REG_WR_PTR_LO  = 13;
    localparam int REG_WR_PTR_HI  = 14;

    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] BLUE   = 3'b001;
    localparam logic [2:0] RED    = 3'b100;

    localparam int CS_ADDR_INC  = 0;
    localparam int CS_INIT_DONE = 1;
    localparam int RGL_FG_LSB   = 0;
    localparam int RGL_BG_LSB   = 4;
    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_LVL_LSB   = 4;

    localparam int X_ORIG_RST = 96;
    localparam int Y_ORIG_RST = 0;
    localparam int X_SIZE_RST = 32;
    localparam int Y_SIZE_RST = 48;

    function automatic logic [7:0] rgl_pack(input logic [2:0] bg, input logic [2:0] fg);
        return {1'b0, bg, 1'b0, fg};
    endfunction

endpackage

// File: rtl/disp_cb_fifo.sv
// Sync FIFO with first-word-fall-through head; 1-cycle push-to-head latency.
// A push while full is taken only if a pop happens on the same edge.
module disp_cb_fifo #(
    parameter int W     = 19,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_wr, do_rd;

    assign do_rd = pop_i & ~empty_o;
    assign do_wr = push_i & (~full_o | do_rd);

    always_comb begin
        cnt_d = cnt_q;
        if (do_wr && !do_rd)
            cnt_d = cnt_q + 1'b1;
        else if (!do_wr && do_rd)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_wr)
                wptr_q <= wptr_q + 1'b1;
            if (do_rd)
                rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr)
            mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign level_o = cnt_q;

endmodule

// File: rtl/disp_regbank.sv
// Display register bank: geometry/colour/cursor regs, registered readback (DISP_REGBANK_READBACK_EN),
// and a char-write FIFO draining to the char buffer; writes land 1 edge after the strobe.
// Char-buffer drain holds head stable while cb_wr_rdy is low; pushes into a full FIFO set ovf.
module disp_regbank
    import disp_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int CB_AW      = 11,
    parameter int CB_DEPTH   = 2048,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              blk_sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] cw_x_orig,
    output logic [DATA_W-1:0] cw_y_orig,
    output logic [DATA_W-1:0] cw_x_size,
    output logic [DATA_W-1:0] cw_y_size,
    output logic [2:0]        char_fg_rgl,
    output logic [2:0]        char_bg_rgl,
    output logic [2:0]        graph_fg_rgl,
    output logic [2:0]        graph_bg_rgl,
    output logic [DATA_W-1:0] cw_row,
    output logic [DATA_W-1:0] cw_col,
    output logic              cw_row_col_update,
    output logic              buffer_init_done,
    output logic              cb_wr_en,
    input  logic              cb_wr_rdy,
    output logic [CB_AW-1:0]  cb_wr_addr,
    output logic [DATA_W-1:0] cb_wr_data
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = CB_AW + DATA_W;

    logic [DATA_W-1:0] cs_q, xo_q, yo_q, xs_q, ys_q, org_lo_q, org_hi_q;
    logic [DATA_W-1:0] crgl_q, grgl_q, row_q, col_q;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [CB_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic              upd_q, ovf_q, ovf_d;
    logic              wr_hit, push_req, push_ok, pop, ovf_set, st_rd;
    logic              fifo_empty, fifo_full;
    logic [LVL_W-1:0]  fifo_lvl;
    logic [ENT_W-1:0]  head;

    assign wr_hit   = blk_sel & wr_en;
    assign push_req = wr_hit & (addr == ADDR_W'(REG_CB_WR_DATA));
    assign pop      = ~fifo_empty & cb_wr_rdy;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok  = push_req & (~fifo_full | pop);
    assign ovf_set  = push_req & fifo_full & ~pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q     <= '0;
            xo_q     <= DATA_W'(X_ORIG_RST);
            yo_q     <= DATA_W'(Y_ORIG_RST);
            xs_q     <= DATA_W'(X_SIZE_RST);
            ys_q     <= DATA_W'(Y_SIZE_RST);
            org_lo_q <= '0;
            org_hi_q <= '0;
            crgl_q   <= DATA_W'(rgl_pack(BLACK, YELLOW));
            grgl_q   <= DATA_W'(rgl_pack(BLUE, RED));
            row_q    <= '0;
            col_q    <= '0;
            upd_q    <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            if (wr_hit) begin
                case (addr)
                    ADDR_W'(REG_CW_CS):      cs_q     <= wr_data;
                    ADDR_W'(REG_X_ORIG):     xo_q     <= wr_data;
                    ADDR_W'(REG_Y_ORIG):     yo_q     <= wr_data;
                    ADDR_W'(REG_X_SIZE):     xs_q     <= wr_data;
                    ADDR_W'(REG_Y_SIZE):     ys_q     <= wr_data;
                    ADDR_W'(REG_CB_ORIG_LO): org_lo_q <= wr_data;
                    ADDR_W'(REG_CB_ORIG_HI): org_hi_q <= wr_data;
                    ADDR_W'(REG_CHAR_RGL):   crgl_q   <= wr_data;
                    ADDR_W'(REG_GRAPH_RGL):  grgl_q   <= wr_data;
                    ADDR_W'(REG_CW_ROW): begin
                        row_q <= wr_data;
                        upd_q <= 1'b1;
                    end
                    ADDR_W'(REG_CW_COL): begin
                        col_q <= wr_data;
                        upd_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (wr_hit && addr == ADDR_W'(REG_CB_ORIG_LO))
            wr_ptr_d = CB_AW'({org_hi_q, wr_data});
        else if (wr_hit && addr == ADDR_W'(REG_CB_ORIG_HI))
            wr_ptr_d = CB_AW'({wr_data, org_lo_q});
        else if (push_ok && cs_q[CS_ADDR_INC])
            wr_ptr_d = (wr_ptr_q == CB_AW'(CB_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end

    // Set beats the read-clear when both land on one edge.
    assign ovf_d = ovf_set ? 1'b1 : (st_rd ? 1'b0 : ovf_q);

`ifdef DISP_REGBANK_READBACK_EN
    logic                rd_hit;
    logic [DATA_W-1:0]   rd_mux, status;
    logic [2*DATA_W-1:0] ptr_ext;

    assign rd_hit  = blk_sel & rd_en;
    assign st_rd   = rd_hit & (addr == ADDR_W'(REG_STATUS));
    assign ptr_ext = (2*DATA_W)'(wr_ptr_q);

    always_comb begin
        status = '0;
        status[ST_EMPTY] = fifo_empty;
        status[ST_FULL]  = fifo_full;
        status[ST_OVF]   = ovf_q;
        status[ST_LVL_LSB +: 4] = (32'(fifo_lvl) > 32'd15) ? 4'hF : 4'(fifo_lvl);
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            ADDR_W'(REG_CW_CS):      rd_mux = cs_q;
            ADDR_W'(REG_X_ORIG):     rd_mux = xo_q;
            ADDR_W'(REG_Y_ORIG):     rd_mux = yo_q;
            ADDR_W'(REG_X_SIZE):     rd_mux = xs_q;
            ADDR_W'(REG_Y_SIZE):     rd_mux = ys_q;
            ADDR_W'(REG_CB_ORIG_LO): rd_mux = org_lo_q;
            ADDR_W'(REG_CB_ORIG_HI): rd_mux = org_hi_q;
            ADDR_W'(REG_CHAR_RGL):   rd_mux = crgl_q;
            ADDR_W'(REG_GRAPH_RGL):  rd_mux = grgl_q;
            ADDR_W'(REG_CW_ROW):     rd_mux = row_q;
            ADDR_W'(REG_CW_COL):     rd_mux = col_q;
            ADDR_W'(REG_STATUS):     rd_mux = status;
            ADDR_W'(REG_WR_PTR_LO):  rd_mux = ptr_ext[DATA_W-1:0];
            ADDR_W'(REG_WR_PTR_HI):  rd_mux = ptr_ext[2*DATA_W-1:DATA_W];
            default:                 rd_mux = '0;
        endcase
    end

    assign rd_data_d = rd_hit ? rd_mux : rd_data_q;
`else
    logic unused_rb;
    assign unused_rb = ^{rd_en, cs_q, crgl_q, grgl_q, fifo_lvl};
    assign st_rd     = 1'b0;
    assign rd_data_d = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            ovf_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            ovf_q     <= ovf_d;
            rd_data_q <= rd_data_d;
        end
    end

    disp_cb_fifo #(
        .W     (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_req),
        .wdata_i ({wr_ptr_q, wr_data}),
        .pop_i   (pop),
        .rdata_o (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (fifo_lvl)
    );

    assign rd_data           = rd_data_q;
    assign cw_x_orig         = xo_q;
    assign cw_y_orig         = yo_q;
    assign cw_x_size         = xs_q;
    assign cw_y_size         = ys_q;
    assign char_fg_rgl       = crgl_q[RGL_FG_LSB +: 3];
    assign char_bg_rgl       = crgl_q[RGL_BG_LSB +: 3];
    assign graph_fg_rgl      = grgl_q[RGL_FG_LSB +: 3];
    assign graph_bg_rgl      = grgl_q[RGL_BG_LSB +: 3];
    assign cw_row            = row_q;
    assign cw_col            = col_q;
    assign cw_row_col_update = upd_q;
    assign buffer_init_done  = cs_q[CS_INIT_DONE];
    assign cb_wr_en          = ~fifo_empty;
    assign {cb_wr_addr, cb_wr_data} = head;

endmodule

// File: tb/tb_disp_regbank.sv
// Randomised bench for disp_regbank against a queue-based register-map model.
module tb_disp_regbank;
    localparam int CB_DEPTH = 2048;
    localparam int FD       = 8;
`ifdef DISP_REGBANK_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        clk, rst, blk_sel, wr_en, rd_en, cb_wr_rdy;
    logic [3:0]  addr;
    logic [7:0]  wr_data, rd_data;
    logic [7:0]  cw_x_orig, cw_y_orig, cw_x_size, cw_y_size, cw_row, cw_col, cb_wr_data;
    logic [2:0]  char_fg_rgl, char_bg_rgl, graph_fg_rgl, graph_bg_rgl;
    logic        cw_row_col_update, buffer_init_done, cb_wr_en;
    logic [10:0] cb_wr_addr;

    disp_regbank dut (
        .clk(clk), .rst(rst), .blk_sel(blk_sel), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
        .wr_data(wr_data), .rd_data(rd_data),
        .cw_x_orig(cw_x_orig), .cw_y_orig(cw_y_orig), .cw_x_size(cw_x_size), .cw_y_size(cw_y_size),
        .char_fg_rgl(char_fg_rgl), .char_bg_rgl(char_bg_rgl),
        .graph_fg_rgl(graph_fg_rgl), .graph_bg_rgl(graph_bg_rgl),
        .cw_row(cw_row), .cw_col(cw_col), .cw_row_col_update(cw_row_col_update),
        .buffer_init_done(buffer_init_done),
        .cb_wr_en(cb_wr_en), .cb_wr_rdy(cb_wr_rdy), .cb_wr_addr(cb_wr_addr), .cb_wr_data(cb_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int a; int d; } ent_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   mreg [11];
    ent_t q [$];
    int   m_ptr, m_rd;
    bit   m_ovf, m_upd;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mreg  = '{0, 96, 0, 32, 48, 0, 0, 'h06, 'h14, 0, 0};
        m_ptr = 0;
        m_ovf = 0;
        m_rd  = 0;
        m_upd = 0;
        q.delete();
    endfunction

    function automatic int read_val(input int a);
        int sz = q.size();
        if (a <= 10) return mreg[a];
        if (a == 12) return ((sz > 15 ? 15 : sz) << 4) | (int'(m_ovf) << 2)
                            | (int'(sz == FD) << 1) | int'(sz == 0);
        if (a == 13) return m_ptr % 256;
        if (a == 14) return m_ptr / 256;
        return 0;
    endfunction

    function automatic void model_step(input bit r, input bit bs, input int a, input bit we,
                                       input bit re, input int wd, input bit rdy);
        bit wr = bs && we;
        bit rd = bs && re;
        bit pop, set, clr;
        int sz;
        ent_t e;
        if (r) begin
            model_reset();
            return;
        end
        sz    = q.size();
        pop   = (sz > 0) && rdy;
        m_upd = wr && (a == 9 || a == 10);
        if (RB && rd) m_rd = read_val(a);
        clr = RB && rd && (a == 12);
        set = 0;
        if (pop) q.delete(0);
        if (wr && a <= 10) begin
            mreg[a] = wd;
            if (a == 5 || a == 6) m_ptr = ((mreg[6] << 8) | mreg[5]) % CB_DEPTH;
        end else if (wr && a == 11) begin
            if (sz < FD || pop) begin
                e.a = m_ptr;
                e.d = wd;
                q.push_back(e);
                if (mreg[0] & 1) m_ptr = (m_ptr + 1) % CB_DEPTH;
            end else begin
                set = 1;
            end
        end
        if (set) m_ovf = 1;
        else if (clr) m_ovf = 0;
    endfunction

    task automatic compare_all();
        check_eq("rd_data", rd_data, 64'(m_rd));
        check_eq("cb_wr_en", cb_wr_en, q.size() != 0);
        if (q.size() != 0) begin
            check_eq("cb_wr_addr", cb_wr_addr, 64'(q[0].a));
            check_eq("cb_wr_data", cb_wr_data, 64'(q[0].d));
        end
        check_eq("update", cw_row_col_update, m_upd);
        check_eq("geometry", {cw_x_orig, cw_y_orig, cw_x_size, cw_y_size},
                 {8'(mreg[1]), 8'(mreg[2]), 8'(mreg[3]), 8'(mreg[4])});
        check_eq("colours", {char_fg_rgl, char_bg_rgl, graph_fg_rgl, graph_bg_rgl},
                 {3'(mreg[7]), 3'(mreg[7] >> 4), 3'(mreg[8]), 3'(mreg[8] >> 4)});
        check_eq("cursor", {cw_row, cw_col}, {8'(mreg[9]), 8'(mreg[10])});
        check_eq("init_done", buffer_init_done, (mreg[0] >> 1) & 1);
    endtask

    // Inputs change at the falling edge; outputs are compared at the next falling edge.
    task automatic cyc(input bit r, input bit bs, input int a, input bit we, input bit re,
                       input int wd, input bit rdy);
        rst = r; blk_sel = bs; addr = 4'(a); wr_en = we; rd_en = re;
        wr_data = 8'(wd); cb_wr_rdy = rdy;
        model_step(r, bs, a, we, re, wd, rdy);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic wr(input int a, input int d, input bit rdy);
        cyc(0, 1, a, 1, 0, d, rdy);
    endtask

    task automatic rd(input int a, input bit rdy);
        cyc(0, 1, a, 0, 1, 0, rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, rdy);
    endtask

    initial begin
        rst = 1; blk_sel = 0; addr = 0; wr_en = 0; rd_en = 0; wr_data = 0; cb_wr_rdy = 0;
        model_reset();
        @(negedge clk);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);

        for (int a = 0; a < 16; a++) rd(a, 0);

        wr(0, 1, 1); wr(6, 'h07, 1); wr(5, 'hFE, 1);
        wr(11, 'hA, 1); wr(11, 'hB, 1); wr(11, 'hC, 1);
        idle(3, 1);
        rd(13, 1); rd(14, 1);

        for (int i = 0; i < 9; i++) wr(11, 'h20 + i, 0);
        rd(12, 0); rd(12, 0);
        wr(11, 'h55, 1);
        rd(12, 0);
        idle(10, 1);

        wr(9, 5, 1); wr(10, 7, 1); idle(2, 1);

        wr(0, 0, 0);
        for (int i = 0; i < 3; i++) wr(11, 'h31 + i, 0);
        wr(6, 'h01, 0); wr(5, 'h00, 0);
        wr(11, 'h44, 0);
        idle(6, 1);
        rd(13, 0); rd(14, 0);

        for (int i = 0; i < 3; i++) wr(11, 'h60 + i, 0);
        cyc(1, 0, 0, 0, 0, 0, 1);
        idle(2, 1);

        for (int i = 0; i < 4000; i++) begin
            bit slow = ((i / 64) % 2) == 1;
            int a    = ($urandom_range(0, 1) == 0) ? 11 : int'($urandom_range(0, 15));
            cyc($urandom_range(0, 999) == 0, $urandom_range(0, 7) != 0, a,
                $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                int'($urandom_range(0, 255)),
                slow ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
